datapath_seq: RTL and testbench

Parametrised single-bus CPU datapath; the next generation of the team's 32-bit bus datapath. Register width and GPR count are parametrised. Bus-source priority is defined. An iterative signed multiply/divide engine runs behind a busy/done handshake in place of single-cycle MUL/DIV. The block sits between the control unit (which drives all strobes) and memory (MDR data path); it is the only bus driver in the CPU.

---
 rtl/datapath_pkg.sv | 15 +
 rtl/datapath_if.sv | 27 ++
 rtl/muldiv_seq.sv | 82 ++++++++
 rtl/datapath_seq.sv | 83 ++++++++
 tb/tb_datapath_seq.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// datapath_pkg: ALU opcodes and mul/div engine state encoding shared by the datapath
package datapath_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_NEG = 4'd6;
  localparam logic [3:0] ALU_NOT = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
endpackage

// File: rtl/datapath_if.sv
// datapath_if: control-unit/memory side of the datapath
//   master: control strobes, memory/inport/constant data in; bus, IR, MAR, engine status out
//   slave : the datapath itself
interface datapath_if #(parameter int REG_SIZE = 32, parameter int NUM_GPR = 16);
  localparam int SEL_W = $clog2(NUM_GPR);
  logic [SEL_W-1:0] r_sel;
  logic r_in, r_out, ba_out;
  logic hi_in, lo_in, pc_in, ir_in, y_in, mar_in, mdr_in;
  logic hi_out, lo_out, pc_out, mdr_out, z_high_out, z_low_out, inport_out, c_out;
  logic read, z_in, inc_pc;
  logic [3:0] alu_op;
  logic [REG_SIZE-1:0] m_data_in, inport_data, c_value;
  logic [REG_SIZE-1:0] bus_data, ir_data, mar_data;
  logic busy, done, div_zero;
  modport master (
    output r_sel, r_in, r_out, ba_out, hi_in, lo_in, pc_in, ir_in, y_in, mar_in, mdr_in,
           hi_out, lo_out, pc_out, mdr_out, z_high_out, z_low_out, inport_out, c_out,
           read, z_in, inc_pc, alu_op, m_data_in, inport_data, c_value,
    input  bus_data, ir_data, mar_data, busy, done, div_zero
  );
  modport slave (
    input  r_sel, r_in, r_out, ba_out, hi_in, lo_in, pc_in, ir_in, y_in, mar_in, mdr_in,
           hi_out, lo_out, pc_out, mdr_out, z_high_out, z_low_out, inport_out, c_out,
           read, z_in, inc_pc, alu_op, m_data_in, inport_data, c_value,
    output bus_data, ir_data, mar_data, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: radix-2 signed multiply/divide, one bit per cycle, REG_SIZE cycles per op
//   in : clk, reset, start, is_div, a, b
//   out: busy, done (pulse after the result edge), div_zero, fin (final step this cycle),
//        result {hi,lo} valid while fin is high
module muldiv_seq import datapath_pkg::*; #(parameter int REG_SIZE = 32) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    is_div,
  input  logic [REG_SIZE-1:0]     a,
  input  logic [REG_SIZE-1:0]     b,
  output logic                    busy,
  output logic                    done,
  output logic                    div_zero,
  output logic                    fin,
  output logic [2*REG_SIZE-1:0]   result
);
  localparam int N  = REG_SIZE;
  localparam int CW = $clog2(REG_SIZE);
  logic [0:0] r_state;
  logic [CW-1:0] r_cnt;
  logic r_div, r_sa, r_sb, r_done, r_dz;
  logic [N-1:0] r_a, r_bm, r_q;
  logic [2*N-1:0] r_acc;
  logic [N:0] w_trial;
  logic [N-1:0] w_sub, w_q, w_quo, w_rem;
  logic [2*N-1:0] w_acc;
  logic w_ge, w_dz, w_neg;
  // Works on magnitudes; r_q holds |a| and is consumed MSB first as multiplier bits
  // or dividend bits, and collects quotient bits from the LSB end for DIV.
  assign w_trial = {r_acc[N-1:0], r_q[N-1]};
  assign w_ge    = w_trial >= {1'b0, r_bm};
  assign w_sub   = w_trial[N-1:0] - r_bm;
  assign w_acc   = r_div ? {{N{1'b0}}, w_ge ? w_sub : w_trial[N-1:0]}
                         : {r_acc[2*N-2:0], 1'b0} + (r_q[N-1] ? {{N{1'b0}}, r_bm} : '0);
  assign w_q     = {r_q[N-2:0], r_div & w_ge};
  assign w_neg   = r_sa ^ r_sb;
  assign w_dz    = r_div && r_bm == '0;
  assign w_quo   = w_neg ? -w_q : w_q;
  assign w_rem   = r_sa ? -w_acc[N-1:0] : w_acc[N-1:0];
  assign result  = !r_div ? (w_neg ? -w_acc : w_acc) : w_dz ? {r_a, {N{1'b1}}} : {w_rem, w_quo};
  assign busy    = r_state == S_RUN;
  assign fin     = busy && r_cnt == CW'(N - 1);
  assign done    = r_done;
  assign div_zero = r_dz;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_a     <= '0;
      r_bm    <= '0;
      r_q     <= '0;
      r_acc   <= '0;
    end else begin
      r_done <= fin;
      if (r_state == S_IDLE && start) begin
        r_state <= S_RUN;
        r_cnt   <= '0;
        r_div   <= is_div;
        r_sa    <= a[N-1];
        r_sb    <= b[N-1];
        r_a     <= a;
        r_bm    <= b[N-1] ? -b : b;
        r_q     <= a[N-1] ? -a : a;
        r_acc   <= '0;
        r_dz    <= 1'b0;
      end else if (busy) begin
        r_acc <= w_acc;
        r_q   <= w_q;
        r_cnt <= r_cnt + 1'b1;
        if (fin) begin
          r_state <= S_IDLE;
          r_dz    <= w_dz;
        end
      end
    end
endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: single-bus CPU datapath with GPRs, HI/LO/PC/IR/Y/MAR/MDR/Z, ALU and mul/div engine
//   clk, reset : clock, asynchronous active-high reset
//   dp (slave) : control strobes and data in; bus_data, ir_data, mar_data, busy, done, div_zero out
module datapath_seq import datapath_pkg::*; #(
  parameter int REG_SIZE = 32,
  parameter int NUM_GPR  = 16,
  parameter int PC_INC   = 4
) (
  input logic       clk,
  input logic       reset,
  datapath_if.slave dp
);
  localparam int N = REG_SIZE;
  logic [N-1:0] r_gpr [NUM_GPR];
  logic [N-1:0] r_hi, r_lo, r_pc, r_ir, r_y, r_mar, r_mdr;
  logic [2*N-1:0] r_z;
  logic [N-1:0] w_bus, w_a, w_alu;
  logic [2*N-1:0] w_md;
  logic w_start, w_fin;
  // Fixed source priority: the first active strobe in this chain owns the bus.
  always_comb
    w_bus = dp.r_out      ? ((dp.ba_out && dp.r_sel == '0) ? '0 : r_gpr[dp.r_sel]) :
            dp.hi_out     ? r_hi :
            dp.lo_out     ? r_lo :
            dp.z_high_out ? r_z[2*N-1:N] :
            dp.z_low_out  ? r_z[N-1:0] :
            dp.pc_out     ? r_pc :
            dp.mdr_out    ? r_mdr :
            dp.inport_out ? dp.inport_data :
            dp.c_out      ? dp.c_value : '0;
  assign w_a = dp.inc_pc ? REG_SIZE'(PC_INC) : r_y;
  always_comb
    w_alu = dp.alu_op == ALU_ADD ? w_a + w_bus :
            dp.alu_op == ALU_SUB ? w_a - w_bus :
            dp.alu_op == ALU_AND ? w_a & w_bus :
            dp.alu_op == ALU_OR  ? w_a | w_bus :
            dp.alu_op == ALU_SHR ? w_a >> w_bus[5:0] :
            dp.alu_op == ALU_SHL ? w_a << w_bus[5:0] :
            dp.alu_op == ALU_NEG ? -w_bus :
            dp.alu_op == ALU_NOT ? ~w_bus : '0;
  assign w_start = dp.z_in && !dp.busy && (dp.alu_op == ALU_MUL || dp.alu_op == ALU_DIV);
  muldiv_seq #(.REG_SIZE(REG_SIZE)) u_md (
    .clk      (clk),
    .reset    (reset),
    .start    (w_start),
    .is_div   (dp.alu_op == ALU_DIV),
    .a        (w_a),
    .b        (w_bus),
    .busy     (dp.busy),
    .done     (dp.done),
    .div_zero (dp.div_zero),
    .fin      (w_fin),
    .result   (w_md)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_gpr <= '{default: '0};
    else if (dp.r_in) r_gpr[dp.r_sel] <= w_bus;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_pc  <= '0;
      r_ir  <= '0;
      r_y   <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_z   <= '0;
    end else begin
      if (dp.hi_in) r_hi <= w_bus;
      if (dp.lo_in) r_lo <= w_bus;
      if (dp.pc_in) r_pc <= w_bus;
      if (dp.ir_in) r_ir <= w_bus;
      if (dp.y_in) r_y <= w_bus;
      if (dp.mar_in) r_mar <= w_bus;
      if (dp.mdr_in) r_mdr <= dp.read ? dp.m_data_in : w_bus;
      // While the engine runs Z is frozen until its final step writes the result.
      if (w_fin) r_z <= w_md;
      else if (dp.z_in && !dp.busy && !w_start) r_z <= {{N{1'b0}}, w_alu};
    end
  assign dp.bus_data = w_bus;
  assign dp.ir_data  = r_ir;
  assign dp.mar_data = r_mar;
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: randomized self-checking bench against a behavioural register/ALU model
module tb_datapath_seq;
  localparam int N = 32;
  localparam int D_Y = 16, D_PC = 17, D_HI = 18, D_LO = 19, D_IR = 20, D_MAR = 21, D_MDR = 22;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  datapath_if #(.REG_SIZE(32), .NUM_GPR(16)) dif ();
  datapath_if #(.REG_SIZE(16), .NUM_GPR(8)) dif16 ();
  datapath_seq #(.REG_SIZE(32), .NUM_GPR(16), .PC_INC(4)) dut (.clk(clk), .reset(reset), .dp(dif));
  datapath_seq #(.REG_SIZE(16), .NUM_GPR(8), .PC_INC(4)) dut16 (.clk(clk), .reset(reset), .dp(dif16));
  int checks = 0, errors = 0;
  logic [31:0] m_gpr [16];
  logic [31:0] m_y, m_pc, m_hi, m_lo, m_ir, m_mar, m_mdr;
  logic [63:0] m_z;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    dif.r_sel = '0; dif.r_in = 0; dif.r_out = 0; dif.ba_out = 0;
    dif.hi_in = 0; dif.lo_in = 0; dif.pc_in = 0; dif.ir_in = 0; dif.y_in = 0; dif.mar_in = 0; dif.mdr_in = 0;
    dif.hi_out = 0; dif.lo_out = 0; dif.pc_out = 0; dif.mdr_out = 0; dif.z_high_out = 0; dif.z_low_out = 0;
    dif.inport_out = 0; dif.c_out = 0; dif.read = 0; dif.z_in = 0; dif.alu_op = '0; dif.inc_pc = 0;
  endtask
  task automatic idle16();
    dif16.r_sel = '0; dif16.r_in = 0; dif16.r_out = 0; dif16.ba_out = 0;
    dif16.hi_in = 0; dif16.lo_in = 0; dif16.pc_in = 0; dif16.ir_in = 0; dif16.y_in = 0; dif16.mar_in = 0; dif16.mdr_in = 0;
    dif16.hi_out = 0; dif16.lo_out = 0; dif16.pc_out = 0; dif16.mdr_out = 0; dif16.z_high_out = 0; dif16.z_low_out = 0;
    dif16.inport_out = 0; dif16.c_out = 0; dif16.read = 0; dif16.z_in = 0; dif16.alu_op = '0; dif16.inc_pc = 0;
    dif16.m_data_in = '0; dif16.inport_data = '0; dif16.c_value = '0;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_gpr[i] = '0;
    m_y = 0; m_pc = 0; m_hi = 0; m_lo = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_z = 0;
  endtask
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a >> b[5:0];
      4'd5: return a << b[5:0];
      4'd6: return 32'd0 - b;
      4'd7: return ~b;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'd8) return 64'(sa * sb);
    if (b == 0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction
  function automatic logic [31:0] ref_bus(input logic [8:0] s, input logic [3:0] sel, input logic ba,
                                          input logic [31:0] inp, input logic [31:0] cv);
    if (s[0]) return (ba && sel == 0) ? 32'd0 : m_gpr[sel];
    if (s[1]) return m_hi;
    if (s[2]) return m_lo;
    if (s[3]) return m_z[63:32];
    if (s[4]) return m_z[31:0];
    if (s[5]) return m_pc;
    if (s[6]) return m_mdr;
    if (s[7]) return inp;
    if (s[8]) return cv;
    return 32'd0;
  endfunction
  task automatic put(input logic [31:0] v, input int dst);
    idle();
    dif.c_out = 1; dif.c_value = v;
    if (dst < 16) begin dif.r_sel = 4'(dst); dif.r_in = 1; end
    else case (dst)
      D_Y: dif.y_in = 1;
      D_PC: dif.pc_in = 1;
      D_HI: dif.hi_in = 1;
      D_LO: dif.lo_in = 1;
      D_IR: dif.ir_in = 1;
      D_MAR: dif.mar_in = 1;
      default: dif.mdr_in = 1;
    endcase
    tick();
    idle();
    if (dst < 16) m_gpr[dst] = v;
    else case (dst)
      D_Y: m_y = v;
      D_PC: m_pc = v;
      D_HI: m_hi = v;
      D_LO: m_lo = v;
      D_IR: m_ir = v;
      D_MAR: m_mar = v;
      default: m_mdr = v;
    endcase
  endtask
  task automatic read_z(output logic [63:0] z);
    idle();
    dif.z_high_out = 1;
    #1 z[63:32] = dif.bus_data;
    dif.z_high_out = 0; dif.z_low_out = 1;
    #1 z[31:0] = dif.bus_data;
    idle();
  endtask
  task automatic alu_c(input logic [3:0] op, input logic [31:0] b, input logic inc);
    logic [63:0] z;
    idle();
    dif.c_out = 1; dif.c_value = b; dif.alu_op = op; dif.inc_pc = inc; dif.z_in = 1;
    tick();
    idle();
    m_z = {32'd0, ref_alu(op, inc ? 32'd4 : m_y, b)};
    read_z(z);
    check("alu_z", z, m_z);
  endtask
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [63:0] exp, z;
    int n;
    put(a, D_Y);
    dif.c_out = 1; dif.c_value = b; dif.alu_op = op; dif.z_in = 1;
    tick();
    idle();
    exp = ref_md(op, a, b);
    check("md_busy", dif.busy, 1);
    n = 0;
    while (!dif.done && n < 40) begin
      if (poke && (n == 5 || n == 9)) begin
        dif.z_low_out = 1;
        #1 check("md_zold", dif.bus_data, m_z[31:0]);
        dif.z_low_out = 0;
        dif.c_out = 1; dif.c_value = 32'd123; dif.z_in = 1; dif.alu_op = (n == 5) ? 4'd0 : 4'd8;
      end
      tick();
      idle();
      n++;
    end
    check("md_latency", n, N);
    check("md_busy_end", dif.busy, 0);
    read_z(z);
    check("md_z", z, exp);
    check("md_divzero", dif.div_zero, op == 4'd9 && b == 0);
    m_z = exp;
    tick();
    check("md_done_pulse", dif.done, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [63:0] z;
    logic [8:0] s;
    logic [3:0] op;
    logic [31:0] b;
    int n, nd;
    idle(); idle16();
    dif.m_data_in = '0; dif.inport_data = '0; dif.c_value = '0;
    tick(); tick();
    check("rst_bus", dif.bus_data, 0);
    check("rst_busy", dif.busy, 0);
    check("rst_done", dif.done, 0);
    check("rst_divzero", dif.div_zero, 0);
    check("rst_ir", dif.ir_data, 0);
    check("rst_mar", dif.mar_data, 0);
    reset = 0;
    model_reset();
    read_z(z);
    check("rst_z", z, 0);
    for (int i = 0; i < 16; i++) put($urandom, i);
    put($urandom, D_HI); put($urandom, D_LO); put($urandom, D_PC);
    put($urandom, D_IR); put($urandom, D_MAR); put($urandom, D_MDR);
    check("ir_load", dif.ir_data, m_ir);
    check("mar_load", dif.mar_data, m_mar);
    dif.read = 1; dif.mdr_in = 1; dif.m_data_in = $urandom; dif.c_out = 1; dif.c_value = $urandom;
    tick();
    m_mdr = dif.m_data_in;
    idle();
    dif.mdr_out = 1;
    #1 check("mdr_read", dif.bus_data, m_mdr);
    idle();
    // Y=7, R3=5 via r_out, ADD
    put(7, D_Y); put(5, 3);
    dif.r_out = 1; dif.r_sel = 4'd3; dif.alu_op = 4'd0; dif.z_in = 1;
    tick();
    idle();
    read_z(z);
    check("add_r3", z, 64'd12);
    m_z = 64'd12;
    put(32'hDEAD_BEEF, 0);
    dif.r_out = 1; dif.r_sel = 4'd0; dif.ba_out = 1;
    #1 check("ba_out_r0", dif.bus_data, 0);
    dif.ba_out = 0;
    #1 check("r0_read", dif.bus_data, m_gpr[0]);
    idle();
    put(32'h100, D_PC);
    dif.pc_out = 1; dif.r_out = 1; dif.r_sel = 4'd3;
    #1 check("prio_r_pc", dif.bus_data, m_gpr[3]);
    idle();
    dif.pc_out = 1; dif.inc_pc = 1; dif.alu_op = 4'd0; dif.z_in = 1;
    tick();
    idle();
    read_z(z);
    check("inc_pc", z, 64'h104);
    m_z = 64'h104;
    for (int i = 0; i < 30; i++) begin
      s = 9'($urandom & $urandom);
      dif.r_out = s[0]; dif.hi_out = s[1]; dif.lo_out = s[2]; dif.z_high_out = s[3]; dif.z_low_out = s[4];
      dif.pc_out = s[5]; dif.mdr_out = s[6]; dif.inport_out = s[7]; dif.c_out = s[8];
      dif.r_sel = 4'($urandom); dif.ba_out = 1'($urandom);
      dif.inport_data = $urandom; dif.c_value = $urandom;
      #1 check("bus_prio", dif.bus_data, ref_bus(s, dif.r_sel, dif.ba_out, dif.inport_data, dif.c_value));
      idle();
      tick();
    end
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd8 || op == 4'd9) op = 4'd0;
      b = (op == 4'd4 || op == 4'd5) ? 32'($urandom_range(0, 40)) : $urandom;
      if (i % 4 == 0) put($urandom, D_Y);
      alu_c(op, b, 1'($urandom));
    end
    run_md(4'd8, 32'hFFFF_FFFA, 32'd7, 1);
    check("mul_m6x7", m_z, 64'hFFFF_FFFF_FFFF_FFD6);
    run_md(4'd9, 32'hFFFF_FFF9, 32'd2, 1);
    run_md(4'd9, 32'h1234_5678, 32'd0, 0);
    run_md(4'd9, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_md(4'd8, 32'h8000_0000, 32'h8000_0000, 0);
    for (int i = 0; i < 8; i++)
      run_md((i % 2) ? 4'd9 : 4'd8, $urandom, (i % 4 == 3) ? 32'($urandom_range(0, 9)) - 32'd4 : $urandom, 0);
    put(32'd99, D_Y);
    dif.c_out = 1; dif.c_value = 32'd3; dif.alu_op = 4'd8; dif.z_in = 1;
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();
    #2 reset = 1;
    #1 check("abort_busy", dif.busy, 0);
    check("abort_done", dif.done, 0);
    dif.z_low_out = 1;
    #1 check("abort_z", dif.bus_data, 0);
    idle();
    dif.r_out = 1; dif.r_sel = 4'd5;
    #1 check("abort_gpr", dif.bus_data, 0);
    idle();
    tick();
    reset = 0;
    model_reset();
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dif.done) nd++;
    end
    check("abort_nodone", nd, 0);
    read_z(z);
    check("abort_z_after", z, 0);
    // 16-bit build
    dif16.c_out = 1; dif16.c_value = 16'h7FFF; dif16.y_in = 1;
    tick();
    dif16.y_in = 0; dif16.alu_op = 4'd8; dif16.z_in = 1;
    tick();
    idle16();
    n = 0;
    while (!dif16.done && n < 30) begin
      tick();
      n++;
    end
    check("w16_latency", n, 16);
    dif16.z_high_out = 1;
    #1 z[31:16] = dif16.bus_data;
    dif16.z_high_out = 0; dif16.z_low_out = 1;
    #1 z[15:0] = dif16.bus_data;
    idle16();
    check("w16_mul", {32'd0, z[31:0]}, 64'(32'(32767 * 32767)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
